// File: rtl/seq_match_monitor_if.sv
// Bundles the detector input, control inputs and statistics/report outputs
// of the match monitor. The master side is the monitor itself; the slave
// side is whatever drives the detector input and consumes the report.
interface seq_match_monitor_if #(
  parameter int CNT_W = 8
);
  logic             det;
  logic             en;
  logic             clr;
  logic [CNT_W-1:0] win_cnt;
  logic [CNT_W-1:0] total_cnt;
  logic             rpt_valid;
  logic             rpt_ready;
  logic [CNT_W-1:0] rpt_data;
  logic             alarm;
  logic             overrun;

  modport master (
    input  det, en, clr, rpt_ready,
    output win_cnt, total_cnt, rpt_valid, rpt_data, alarm, overrun
  );

  modport slave (
    output det, en, clr, rpt_ready,
    input  win_cnt, total_cnt, rpt_valid, rpt_data, alarm, overrun
  );
endinterface

// File: rtl/seq_match_monitor.sv
// Match statistics monitor: counts rising edges of the detector output per
// fixed window of enabled cycles, keeps a saturating total, publishes each
// closed window's count on a valid/ready report port and raises sticky
// alarm (threshold reached) and overrun (report overwritten) flags.
module seq_match_monitor #(
  parameter int CNT_W   = 8,
  parameter int WIN_LEN = 64,
  parameter int THRESH  = 4
) (
  input logic                clk,
  input logic                rst,
  seq_match_monitor_if.master bus
);

  localparam int TMR_W = (WIN_LEN > 2) ? $clog2(WIN_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(WIN_LEN - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t           state_reg, state_next;
  logic             det_prev_reg, det_prev_next;
  logic [TMR_W-1:0] timer_reg, timer_next;
  logic [CNT_W-1:0] win_cnt_reg, win_cnt_next;
  logic [CNT_W-1:0] total_cnt_reg, total_cnt_next;
  logic             rpt_valid_reg, rpt_valid_next;
  logic [CNT_W-1:0] rpt_data_reg, rpt_data_next;
  logic             alarm_reg, alarm_next;
  logic             overrun_reg, overrun_next;

  // Combinational helpers shared by the next-state logic.
  logic             match_evt;
  logic             terminal;
  logic [CNT_W-1:0] win_inc;
  logic [CNT_W-1:0] total_inc;

  // Edge detection, saturating increments and window-close detection.
  always_comb begin
    match_evt = bus.en & bus.det & ~det_prev_reg;
    terminal  = bus.en && (timer_reg == TMR_LAST);
    win_inc   = (match_evt && (win_cnt_reg != CNT_MAX)) ? win_cnt_reg + 1'b1 : win_cnt_reg;
    total_inc = (match_evt && (total_cnt_reg != CNT_MAX)) ? total_cnt_reg + 1'b1 : total_cnt_reg;
  end

  // Next-state logic: FSM transitions plus counter, report and flag updates.
  always_comb begin
    state_next     = state_reg;
    det_prev_next  = det_prev_reg;
    timer_next     = timer_reg;
    win_cnt_next   = win_cnt_reg;
    total_cnt_next = total_cnt_reg;
    rpt_valid_next = rpt_valid_reg;
    rpt_data_next  = rpt_data_reg;
    alarm_next     = alarm_reg;
    overrun_next   = overrun_reg;

    case (state_reg)
      IDLE:    if (bus.en)  state_next = RUN;
      RUN:     if (!bus.en) state_next = PAUSE;
      PAUSE:   if (bus.en)  state_next = RUN;
      default: state_next = IDLE;
    endcase

    // Every enabled cycle advances the window, whichever state it starts in;
    // an event on the closing cycle still belongs to the closing window.
    if (bus.en) begin
      det_prev_next  = bus.det;
      timer_next     = terminal ? '0 : timer_reg + TMR_W'(1);
      win_cnt_next   = terminal ? '0 : win_inc;
      total_cnt_next = total_inc;
      if (win_inc >= THRESH_C) alarm_next = 1'b1;
    end

    // A new report wins over an acceptance on the same cycle; overwriting
    // a report the consumer has not taken is recorded as an overrun.
    if (terminal) begin
      rpt_valid_next = 1'b1;
      rpt_data_next  = win_inc;
      if (rpt_valid_reg && !bus.rpt_ready) overrun_next = 1'b1;
    end else if (rpt_valid_reg && bus.rpt_ready) begin
      rpt_valid_next = 1'b0;
    end

    if (bus.clr) begin
      state_next     = IDLE;
      det_prev_next  = 1'b0;
      timer_next     = '0;
      win_cnt_next   = '0;
      total_cnt_next = '0;
      rpt_valid_next = 1'b0;
      rpt_data_next  = '0;
      alarm_next     = 1'b0;
      overrun_next   = 1'b0;
    end
  end

  // State and datapath registers; reset discards any partial window at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      det_prev_reg  <= 1'b0;
      timer_reg     <= '0;
      win_cnt_reg   <= '0;
      total_cnt_reg <= '0;
      rpt_valid_reg <= 1'b0;
      rpt_data_reg  <= '0;
      alarm_reg     <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      det_prev_reg  <= det_prev_next;
      timer_reg     <= timer_next;
      win_cnt_reg   <= win_cnt_next;
      total_cnt_reg <= total_cnt_next;
      rpt_valid_reg <= rpt_valid_next;
      rpt_data_reg  <= rpt_data_next;
      alarm_reg     <= alarm_next;
      overrun_reg   <= overrun_next;
    end
  end

  assign bus.win_cnt   = win_cnt_reg;
  assign bus.total_cnt = total_cnt_reg;
  assign bus.rpt_valid = rpt_valid_reg;
  assign bus.rpt_data  = rpt_data_reg;
  assign bus.alarm     = alarm_reg;
  assign bus.overrun   = overrun_reg;

endmodule

// File: tb/tb_seq_match_monitor.sv
// Self-checking bench for seq_match_monitor: directed scenarios plus a
// randomized run compared every cycle against a behavioural model that
// tracks counts as plain integers and window position as a modulo count
// of enabled cycles.
module tb_seq_match_monitor;

  localparam int CNT_W   = 8;
  localparam int WIN_LEN = 64;
  localparam int THRESH  = 4;
  localparam int CMAX    = (1 << CNT_W) - 1;
  localparam int VEC_W   = 3 * CNT_W + 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  seq_match_monitor_if #(.CNT_W(CNT_W)) bus ();

  seq_match_monitor #(
    .CNT_W  (CNT_W),
    .WIN_LEN(WIN_LEN),
    .THRESH (THRESH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state.
  bit m_prev;
  int m_pos;
  int m_w;
  int m_t;
  bit m_rv;
  int m_rd;
  bit m_alarm;
  bit m_ovr;

  task automatic model_reset();
    m_prev = 0; m_pos = 0; m_w = 0; m_t = 0;
    m_rv = 0; m_rd = 0; m_alarm = 0; m_ovr = 0;
  endtask

  // One clock of the model, from the inputs present before the edge.
  task automatic model_step(input bit d, input bit e, input bit c, input bit r);
    bit ev;
    bit acc;
    bit load;
    acc  = m_rv && r;
    load = 0;
    if (c) begin
      model_reset();
    end else begin
      if (e) begin
        ev     = d && !m_prev;
        m_prev = d;
        if (ev) begin
          m_w = (m_w < CMAX) ? m_w + 1 : CMAX;
          m_t = (m_t < CMAX) ? m_t + 1 : CMAX;
        end
        if (m_w >= THRESH) m_alarm = 1;
        if (m_pos == WIN_LEN - 1) begin
          load = 1;
          m_rd = m_w;
          m_w  = 0;
        end
        m_pos = (m_pos + 1) % WIN_LEN;
      end
      if (load) begin
        if (m_rv && !r) m_ovr = 1;
        m_rv = 1;
      end else if (acc) begin
        m_rv = 0;
      end
    end
  endtask

  function automatic logic [VEC_W-1:0] exp_vec();
    return {CNT_W'(m_w), CNT_W'(m_t), m_rv, CNT_W'(m_rd), m_alarm, m_ovr};
  endfunction

  function automatic logic [VEC_W-1:0] act_vec();
    return {bus.win_cnt, bus.total_cnt, bus.rpt_valid, bus.rpt_data, bus.alarm, bus.overrun};
  endfunction

  // Drive one cycle of inputs, advance the model, sample 1 unit after the edge.
  task automatic step(input bit d, input bit e, input bit c, input bit r);
    bus.det = d; bus.en = e; bus.clr = c; bus.rpt_ready = r;
    model_step(d, e, c, r);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.det = 0; bus.en = 0; bus.clr = 0; bus.rpt_ready = 0;
    model_reset();
    #12;
    checks++;
    if (act_vec() !== '0) begin
      errors++; $display("FAIL reset_state: got %h expected 0", act_vec());
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < 20; c++) step(c == 3 || c == 8, 1, 0, 0);
    checks++;
    if (bus.total_cnt !== 8'd2) begin
      errors++; $display("FAIL pre_reset_total: got %0d expected 2", bus.total_cnt);
    end
    // Asynchronous reset mid-window: outputs clear without a clock edge.
    #2 rst = 1'b0;
    #1;
    model_reset();
    checks++;
    if (act_vec() !== '0) begin
      errors++; $display("FAIL async_reset: got %h expected 0", act_vec());
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    $display("test_reset done");
  endtask

  task automatic test_window_basic();
    step(0, 0, 1, 1);
    for (int c = 0; c < WIN_LEN; c++) step(c == 3 || c == 10 || c == 20, 1, 0, 1);
    checks++;
    if ({bus.rpt_valid, bus.rpt_data, bus.total_cnt, bus.alarm, bus.win_cnt} !== {1'b1, 8'd3, 8'd3, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL window_report: got v=%0b d=%0d tot=%0d al=%0b win=%0d expected v=1 d=3 tot=3 al=0 win=0",
               bus.rpt_valid, bus.rpt_data, bus.total_cnt, bus.alarm, bus.win_cnt);
    end
    step(0, 1, 0, 1);
    checks++;
    if (bus.rpt_valid !== 1'b0) begin
      errors++; $display("FAIL window_accept: got rpt_valid=%0b expected 0", bus.rpt_valid);
    end
    $display("test_window_basic done");
  endtask

  task automatic test_held_high();
    step(0, 0, 1, 1);
    for (int c = 0; c < 20; c++) step(c >= 5 && c < 15, 1, 0, 1);
    checks++;
    if ({bus.win_cnt, bus.total_cnt} !== {8'd1, 8'd1}) begin
      errors++; $display("FAIL held_high: got win=%0d tot=%0d expected win=1 tot=1", bus.win_cnt, bus.total_cnt);
    end
    $display("test_held_high done");
  endtask

  task automatic test_alarm();
    step(0, 0, 1, 1);
    for (int c = 0; c < WIN_LEN; c++) begin
      step(c == 1 || c == 5 || c == 9 || c == 13, 1, 0, 1);
      if (c == 12) begin
        checks++;
        if (bus.alarm !== 1'b0) begin
          errors++; $display("FAIL alarm_early: got %0b expected 0", bus.alarm);
        end
      end
      if (c == 13) begin
        checks++;
        if (bus.alarm !== 1'b1) begin
          errors++; $display("FAIL alarm_rise: got %0b expected 1", bus.alarm);
        end
      end
    end
    for (int c = 0; c < 2 * WIN_LEN; c++) step(0, 1, 0, 1);
    checks++;
    if ({bus.alarm, bus.rpt_data} !== {1'b1, 8'd0}) begin
      errors++; $display("FAIL alarm_sticky: got al=%0b d=%0d expected al=1 d=0", bus.alarm, bus.rpt_data);
    end
    step(0, 1, 1, 1);
    checks++;
    if (bus.alarm !== 1'b0) begin
      errors++; $display("FAIL alarm_clr: got %0b expected 0", bus.alarm);
    end
    $display("test_alarm done");
  endtask

  task automatic test_overrun();
    step(0, 0, 1, 0);
    for (int c = 0; c < WIN_LEN; c++) step(c == 2 || c == 4, 1, 0, 0);
    checks++;
    if ({bus.rpt_valid, bus.rpt_data, bus.overrun} !== {1'b1, 8'd2, 1'b0}) begin
      errors++; $display("FAIL ovr_first: got v=%0b d=%0d ovr=%0b expected v=1 d=2 ovr=0", bus.rpt_valid, bus.rpt_data, bus.overrun);
    end
    for (int c = 0; c < WIN_LEN; c++) begin
      step(c == 3 || c == 6 || c == 9 || c == 12 || c == 15, 1, 0, 0);
      if (c == 30) begin
        checks++;
        if ({bus.rpt_valid, bus.rpt_data} !== {1'b1, 8'd2}) begin
          errors++; $display("FAIL ovr_stable: got v=%0b d=%0d expected v=1 d=2", bus.rpt_valid, bus.rpt_data);
        end
      end
    end
    checks++;
    if ({bus.rpt_valid, bus.rpt_data, bus.overrun} !== {1'b1, 8'd5, 1'b1}) begin
      errors++; $display("FAIL ovr_second: got v=%0b d=%0d ovr=%0b expected v=1 d=5 ovr=1", bus.rpt_valid, bus.rpt_data, bus.overrun);
    end
    step(0, 1, 0, 1);
    checks++;
    if ({bus.rpt_valid, bus.overrun} !== {1'b0, 1'b1}) begin
      errors++; $display("FAIL ovr_accept: got v=%0b ovr=%0b expected v=0 ovr=1", bus.rpt_valid, bus.overrun);
    end
    $display("test_overrun done");
  endtask

  // Pulse on the closing cycle; the next pulse needs det low for a cycle
  // first, so it lands on cycle 1 of the new window.
  task automatic test_terminal();
    step(0, 0, 1, 1);
    for (int c = 0; c < WIN_LEN; c++) step(c == 40 || c == WIN_LEN - 1, 1, 0, 1);
    checks++;
    if ({bus.rpt_valid, bus.rpt_data, bus.win_cnt} !== {1'b1, 8'd2, 8'd0}) begin
      errors++; $display("FAIL term_close: got v=%0b d=%0d win=%0d expected v=1 d=2 win=0", bus.rpt_valid, bus.rpt_data, bus.win_cnt);
    end
    step(0, 1, 0, 1);
    step(1, 1, 0, 1);
    checks++;
    if ({bus.win_cnt, bus.total_cnt} !== {8'd1, 8'd3}) begin
      errors++; $display("FAIL term_next: got win=%0d tot=%0d expected win=1 tot=3", bus.win_cnt, bus.total_cnt);
    end
    $display("test_terminal done");
  endtask

  task automatic test_pause();
    step(0, 0, 1, 1);
    for (int s = 0; s < 84; s++) begin
      if (s >= 30 && s < 50) step(s[0], 0, 0, 1);
      else step(s == 5, 1, 0, 1);
      if (s == 49) begin
        checks++;
        if ({bus.win_cnt, bus.total_cnt} !== {8'd1, 8'd1}) begin
          errors++; $display("FAIL pause_hold: got win=%0d tot=%0d expected win=1 tot=1", bus.win_cnt, bus.total_cnt);
        end
      end
      if (s == WIN_LEN - 1) begin
        checks++;
        if (bus.rpt_valid !== 1'b0) begin
          errors++; $display("FAIL pause_early_close: got rpt_valid=%0b expected 0", bus.rpt_valid);
        end
      end
    end
    checks++;
    if ({bus.rpt_valid, bus.rpt_data} !== {1'b1, 8'd1}) begin
      errors++; $display("FAIL pause_close: got v=%0b d=%0d expected v=1 d=1", bus.rpt_valid, bus.rpt_data);
    end
    $display("test_pause done");
  endtask

  task automatic test_saturation();
    step(0, 0, 1, 1);
    for (int i = 0; i < 300; i++) begin
      step(1, 1, 0, 1);
      step(0, 1, 0, 1);
      if (i == 253) begin
        checks++;
        if (bus.total_cnt !== 8'd254) begin
          errors++; $display("FAIL sat_before: got %0d expected 254", bus.total_cnt);
        end
      end
    end
    checks++;
    if (bus.total_cnt !== 8'd255) begin
      errors++; $display("FAIL sat_total: got %0d expected 255", bus.total_cnt);
    end
    $display("test_saturation done");
  endtask

  // Pending report accepted on the same cycle a new one loads.
  task automatic test_back_to_back();
    step(0, 0, 1, 0);
    for (int c = 0; c < WIN_LEN; c++) step(c == 7, 1, 0, 0);
    for (int c = 0; c < WIN_LEN; c++) step(c == 7 || c == 20 || c == 33, 1, 0, c == WIN_LEN - 1);
    checks++;
    if ({bus.rpt_valid, bus.rpt_data, bus.overrun} !== {1'b1, 8'd3, 1'b0}) begin
      errors++; $display("FAIL b2b_load_accept: got v=%0b d=%0d ovr=%0b expected v=1 d=3 ovr=0", bus.rpt_valid, bus.rpt_data, bus.overrun);
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_random();
    int bad = 0;
    step(0, 0, 1, 1);
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 99) < 40, $urandom_range(0, 99) < 85,
           $urandom_range(0, 499) == 0, $urandom_range(0, 99) < 40);
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++; bad++;
        if (bad <= 10) $display("FAIL random_cycle %0d: got %h expected %h", i, act_vec(), exp_vec());
      end
    end
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_window_basic();
    test_held_high();
    test_alarm();
    test_overrun();
    test_terminal();
    test_pause();
    test_saturation();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
